// File: rtl/st_shifter_pkg.sv
// Shared types, register map and colour helpers for the ST video shifter.
// ST_SHIFTER_STE_PALETTE_EN selects 12-bit STE palette entries; otherwise 9-bit ST.
package st_shifter_pkg;

   typedef enum logic [1:0] {
      RES_LOW  = 2'd0,
      RES_MED  = 2'd1,
      RES_HIGH = 2'd2
   } res_e;

   localparam logic [4:0] PAL_BASE    = 5'd0;
   localparam logic [4:0] RES_ADDR    = 5'd16;

   localparam logic [2:0] PLANES_LOW  = 3'd4;
   localparam logic [2:0] PLANES_MED  = 3'd2;
   localparam logic [2:0] PLANES_HIGH = 3'd1;

   localparam logic [2:0] DOT_DIV_LOW  = 3'd4;
   localparam logic [2:0] DOT_DIV_MED  = 3'd2;
   localparam logic [2:0] DOT_DIV_HIGH = 3'd1;

`ifdef ST_SHIFTER_STE_PALETTE_EN
   localparam logic [11:0] PAL_MASK   = 12'hFFF;
   localparam logic        NIB_LSB_EN = 1'b1;
`else
   localparam logic [11:0] PAL_MASK   = 12'h777;
   localparam logic        NIB_LSB_EN = 1'b0;
`endif

   // Resolution code 3 decodes as high res.
   function automatic logic [2:0] planes_of(input logic [1:0] res);
      case (res)
         RES_LOW: planes_of = PLANES_LOW;
         RES_MED: planes_of = PLANES_MED;
         default: planes_of = PLANES_HIGH;
      endcase
   endfunction

   function automatic logic [2:0] dot_div_of(input logic [1:0] res);
      case (res)
         RES_LOW: dot_div_of = DOT_DIV_LOW;
         RES_MED: dot_div_of = DOT_DIV_MED;
         default: dot_div_of = DOT_DIV_HIGH;
      endcase
   endfunction

   // STE nibbles carry their least significant DAC bit in bit 3.
   function automatic logic [3:0] map_nibble(input logic [3:0] n);
      map_nibble = {n[2:0], n[3] & NIB_LSB_EN};
   endfunction

   function automatic logic [11:0] map_rgb(input logic [11:0] e);
      map_rgb = {map_nibble(e[11:8]), map_nibble(e[7:4]), map_nibble(e[3:0])};
   endfunction

endpackage

// File: rtl/st_shifter_if.sv
// Register and bitplane-load bus between the MMU/GLUE side and the shifter.
interface st_shifter_if;
   // cs low qualifies an access every clock (rw=1 read, rw=0 write); load is an
   // active-low strobe whose sampled release (0->1) captures data as a plane word.
   logic        de;
   logic        cs;
   logic        load;
   logic        rw;
   logic [4:0]  addr;
   logic [15:0] data;
   logic [15:0] data_out;
   logic        oe;

   modport master (output de, cs, load, rw, addr, data, input data_out, oe);
   modport slave  (input de, cs, load, rw, addr, data, output data_out, oe);
endinterface

// File: rtl/st_shifter_palette.sv
// 16-entry colour palette: one write port, async bus read, async pixel lookup.
module st_shifter_palette
   import st_shifter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [3:0]  waddr_i,
   input  logic [11:0] wdata_i,
   input  logic [3:0]  raddr_i,
   output logic [11:0] rdata_o,
   input  logic [3:0]  pix_idx_i,
   output logic [11:0] pix_rgb_o,
   output logic [11:0] border_o
);

   logic [11:0] mem_q [16];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i & PAL_MASK;
      end
   end

   assign rdata_o   = mem_q[raddr_i];
   assign pix_rgb_o = mem_q[pix_idx_i];
   assign border_o  = mem_q[0];

endmodule

// File: rtl/st_shifter.sv
// ST video shifter: palette/resolution registers, bitplane capture and pixel serialiser.
// ST_SHIFTER_STE_PALETTE_EN selects the 12-bit STE palette (see st_shifter_pkg).
module st_shifter
   import st_shifter_pkg::*;
(
   input  logic         CLOCK_32,
   input  logic         RESET_N,
   st_shifter_if.slave  bus,
   output logic [3:0]   shifter_r,
   output logic [3:0]   shifter_g,
   output logic [3:0]   shifter_b
);

   logic        bus_wr, bus_rd, soft_rst, load_rise, pal_we;
   logic [1:0]  res_q, res_d;
   logic        load_q, load_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] latch_q [4];
   logic [15:0] latch_d [4];
   logic [15:0] shift_q [4];
   logic [15:0] shift_d [4];
   logic [1:0]  div_q, div_d;
   logic        xfer_q, xfer_d;
   logic        started_q, started_d;
   logic [11:0] rgb_q, rgb_d;
   logic [2:0]  planes, dot_div;
   logic [3:0]  pix_idx;
   logic [11:0] pal_rd, pal_pix, pal_border;
   logic [15:0] rd_data;
   logic        mono_bit;

   assign bus_wr    = !bus.cs && !bus.rw;
   assign bus_rd    = !bus.cs &&  bus.rw;
   assign soft_rst  = !bus.cs && !bus.load;
   assign load_rise =  bus.load && !load_q;
   assign pal_we    = bus_wr && (bus.addr < PAL_BASE + 5'd16);
   assign planes    = planes_of(res_q);
   assign dot_div   = dot_div_of(res_q);

   st_shifter_palette u_palette (
      .clk_i     (CLOCK_32),
      .rst_ni    (RESET_N),
      .we_i      (pal_we),
      .waddr_i   (bus.addr[3:0]),
      .wdata_i   (bus.data[11:0]),
      .raddr_i   (bus.addr[3:0]),
      .rdata_o   (pal_rd),
      .pix_idx_i (pix_idx),
      .pix_rgb_o (pal_pix),
      .border_o  (pal_border)
   );

   always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
      if (!RESET_N) begin
         res_q     <= '0;
         load_q    <= 1'b1;
         cnt_q     <= '0;
         div_q     <= '0;
         xfer_q    <= 1'b0;
         started_q <= 1'b0;
         rgb_q     <= '0;
         for (int i = 0; i < 4; i++) begin
            latch_q[i] <= '0;
            shift_q[i] <= '0;
         end
      end else begin
         res_q     <= res_d;
         load_q    <= load_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         xfer_q    <= xfer_d;
         started_q <= started_d;
         rgb_q     <= rgb_d;
         for (int i = 0; i < 4; i++) begin
            latch_q[i] <= latch_d[i];
            shift_q[i] <= shift_d[i];
         end
      end
   end

   always_comb begin
      res_d     = res_q;
      load_d    = bus.load;
      cnt_d     = cnt_q;
      latch_d   = latch_q;
      shift_d   = shift_q;
      div_d     = div_q;
      xfer_d    = 1'b0;
      started_d = started_q;

      if (bus_wr && bus.addr == RES_ADDR) res_d = bus.data[1:0];

      if (soft_rst) begin
         // The release of a soft-reset pulse must not count as a plane load.
         load_d = 1'b1;
         cnt_d  = '0;
         div_d  = '0;
         for (int i = 0; i < 4; i++) shift_d[i] = '0;
      end else begin
         if (load_rise) begin
            latch_d[cnt_q] = bus.data;
            if ({1'b0, cnt_q} >= planes - 3'd1) begin
               cnt_d  = '0;
               xfer_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         if (xfer_q) begin
            shift_d   = latch_q;
            div_d     = '0;
            started_d = 1'b1;
         end else if ({1'b0, div_q} >= dot_div - 3'd1) begin
            for (int i = 0; i < 4; i++) shift_d[i] = {shift_q[i][14:0], 1'b0};
            div_d = '0;
         end else begin
            div_d = div_q + 2'd1;
         end
      end
   end

   always_comb begin
      if (res_q == RES_LOW)
         pix_idx = {shift_q[3][15], shift_q[2][15], shift_q[1][15], shift_q[0][15]};
      else if (res_q == RES_MED)
         pix_idx = {2'b00, shift_q[1][15], shift_q[0][15]};
      else
         pix_idx = {3'b000, shift_q[0][15]};

      mono_bit = shift_q[0][15] ^ pal_border[0];

      if (!bus.de || !started_q) rgb_d = map_rgb(pal_border);
      else if (res_q[1])         rgb_d = {12{mono_bit}};
      else                       rgb_d = map_rgb(pal_pix);
   end

   always_comb begin
      rd_data = '0;
      if (bus_rd) begin
         if (bus.addr < PAL_BASE + 5'd16) rd_data = {4'h0, pal_rd};
         else if (bus.addr == RES_ADDR)   rd_data = {14'h0, res_q};
      end
   end

   assign bus.data_out = rd_data;
   assign bus.oe       = bus_rd;
   assign shifter_r    = rgb_q[11:8];
   assign shifter_g    = rgb_q[7:4];
   assign shifter_b    = rgb_q[3:0];

endmodule

// File: tb/tb_st_shifter.sv
// Directed bench for st_shifter: registers, pixel streams per resolution, blanking, resets.
module tb_st_shifter;

`ifdef ST_SHIFTER_STE_PALETTE_EN
   localparam logic [3:0]  DAC_MASK = 4'hF;
   localparam logic [11:0] PAL_KEEP = 12'hFFF;
`else
   localparam logic [3:0]  DAC_MASK = 4'hE;
   localparam logic [11:0] PAL_KEEP = 12'h777;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rgb_r, rgb_g, rgb_b;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [11:0] exp_q[$];
   logic [11:0] pal_init [16];

   st_shifter_if bus();

   st_shifter dut (
      .CLOCK_32  (clk),
      .RESET_N   (rst_n),
      .bus       (bus),
      .shifter_r (rgb_r),
      .shifter_g (rgb_g),
      .shifter_b (rgb_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_rgb(input string tag, input logic [11:0] exp);
      check(tag, {4'h0, rgb_r, rgb_g, rgb_b}, {4'h0, exp});
   endtask

   task automatic reg_write(input logic [4:0] a, input logic [15:0] d);
      bus.cs = 1'b0; bus.rw = 1'b0; bus.addr = a; bus.data = d;
      @(negedge clk);
      bus.cs = 1'b1; bus.rw = 1'b1;
   endtask

   task automatic reg_read(input string tag, input logic [4:0] a, input logic [15:0] exp);
      bus.cs = 1'b0; bus.rw = 1'b1; bus.addr = a;
      #1;
      check(tag, bus.data_out, exp);
      check({tag, "_oe"}, {15'h0, bus.oe}, 16'h0001);
      bus.cs = 1'b1;
      #1;
   endtask

   task automatic load_word(input logic [15:0] d);
      bus.data = d; bus.load = 1'b0;
      @(negedge clk);
      bus.load = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check_rgb(tag, exp_q.pop_front());
      end
   endtask

   task automatic low_group(input string tag);
      logic [3:0] v;
      load_word(16'hAAAA); load_word(16'h6666); load_word(16'h1E1E); load_word(16'h01FE);
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         v = 4'(k + 1) & DAC_MASK;
         repeat (4) exp_q.push_back({v, v, v});
      end
      drain(tag);
   endtask

   initial begin
      logic [3:0] n;
      logic [1:0] idx;
      bus.de = 1'b0; bus.cs = 1'b1; bus.load = 1'b1; bus.rw = 1'b1;
      bus.addr = '0; bus.data = '0;
      for (int i = 0; i < 16; i++) begin
         n = 4'(i / 2) | ((i % 2 == 1) ? 4'h8 : 4'h0);
         pal_init[i] = {n, n, n};
      end

      repeat (2) @(negedge clk);
      check_rgb("reset_rgb", 12'h000);
      check("reset_oe", {15'h0, bus.oe}, 16'h0000);
      check("reset_dout", bus.data_out, 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) reg_write(5'(i), {4'hA, pal_init[i]});
      for (int i = 0; i < 16; i++) reg_read("pal_rd", 5'(i), {4'h0, pal_init[i] & PAL_KEEP});
      reg_write(5'd20, 16'hFFFF);
      reg_read("unmapped_rd", 5'd20, 16'h0000);
      reg_read("pal4_kept", 5'd4, {4'h0, 12'h222 & PAL_KEEP});
      reg_write(5'd16, 16'hFFFF);
      reg_read("res_rd", 5'd16, 16'h0003);
      check("idle_oe", {15'h0, bus.oe}, 16'h0000);
      check("idle_dout", bus.data_out, 16'h0000);

      reg_write(5'd16, 16'h0000);
      bus.de = 1'b1;
      low_group("low_pix");

      reg_write(5'd16, 16'h0001);
      load_word(16'hAAAA); load_word(16'h6666);
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         idx = 2'(k + 1);
         n = {2'b00, idx} & DAC_MASK;
         repeat (2) exp_q.push_back({n, n, n});
      end
      drain("med_pix");

      reg_write(5'd0, 16'h0001);
      reg_write(5'd16, 16'h0002);
      load_word(16'hFF00);
      @(negedge clk);
      repeat (8) exp_q.push_back(12'h000);
      repeat (8) exp_q.push_back(12'hFFF);
      drain("high_pix");
      @(negedge clk);
      check_rgb("high_tail", 12'hFFF);

      reg_write(5'd16, 16'h0000);
      reg_write(5'd0, 16'h0123);
      bus.de = 1'b0;
      load_word(16'hAAAA); load_word(16'h6666); load_word(16'h1E1E); load_word(16'h01FE);
      repeat (16) begin
         @(negedge clk);
         check_rgb("blank_de", 12'h246);
      end

      bus.de = 1'b1;
      reg_write(5'd0, 16'h0000);
      load_word(16'h1234); load_word(16'h5678);
      bus.cs = 1'b0; bus.rw = 1'b1; bus.load = 1'b0;
      @(negedge clk);
      bus.cs = 1'b1; bus.load = 1'b1;
      repeat (3) @(negedge clk);
      check_rgb("soft_rst_shift", 12'h000);
      low_group("soft_rst_pix");

      load_word(16'hAAAA); load_word(16'h6666); load_word(16'h1E1E); load_word(16'h01FE);
      repeat (8) @(negedge clk);
      check_rgb("pre_reset", 12'h222);
      #2 rst_n = 1'b0;
      #1;
      check_rgb("async_reset", 12'h000);
      check("async_reset_oe", {15'h0, bus.oe}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      reg_read("pal_after_reset", 5'd1, 16'h0000);
      reg_read("res_after_reset", 5'd16, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
